// File: rtl/data_mem_port.sv
// Memory-stage data port: one load/store per instruction becomes one or two
// word-aligned bus beats; the pipeline is stalled until the access completes.
module data_mem_port #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              store_mem,
  input  logic              load_mem,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              bus_req,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        split_q;
  logic [3:0]  strb1_q;
  logic [31:0] wdata1_q;
  logic [31:0] beat0_q;

  logic [7:0]  base_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wd_lanes;

  // Shifting over two words: the upper nibble/word is exactly the beat-1 share.
  always_comb begin
    base_mask = 8'h0F;
    case (size)
      2'd1:    base_mask = 8'h01;
      2'd2:    base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    lane_mask = base_mask << addr[1:0];
    wd_lanes  = {32'h0, wdata} << {addr[1:0], 3'b000};
  end

  always_comb begin
    stall = 1'b0;
    if (state == IDLE)
      stall = store_mem | load_mem;
    else if (state != DONE)
      stall = 1'b1;
  end

  function automatic logic [31:0] assemble(input logic [31:0] b0, input logic [31:0] b1,
                                           input logic [1:0] off, input logic [1:0] sz,
                                           input logic uns);
    logic [63:0] cat;
    logic [31:0] r;
    cat = {b1, b0} >> {off, 3'b000};
    r   = cat[31:0];
    case (sz)
      2'd1:    assemble = uns ? {24'h0, r[7:0]}  : {{24{r[7]}},  r[7:0]};
      2'd2:    assemble = uns ? {16'h0, r[15:0]} : {{16{r[15]}}, r[15:0]};
      default: assemble = r;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus_req    <= '0;
      bus_we     <= '0;
      bus_addr   <= '0;
      bus_wstrb  <= '0;
      bus_wdata  <= '0;
      load_valid <= '0;
      load_data  <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= '0;
      split_q    <= '0;
      strb1_q    <= '0;
      wdata1_q   <= '0;
      beat0_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          load_valid <= 1'b0;
          if (store_mem | load_mem) begin
            state     <= REQ0;
            bus_req   <= 1'b1;
            bus_we    <= store_mem;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_wstrb <= store_mem ? lane_mask[3:0]  : '0;
            bus_wdata <= store_mem ? wd_lanes[31:0]  : '0;
            strb1_q   <= store_mem ? lane_mask[7:4]  : '0;
            wdata1_q  <= store_mem ? wd_lanes[63:32] : '0;
            off_q     <= addr[1:0];
            size_q    <= size;
            uns_q     <= load_unsigned;
            split_q   <= |lane_mask[7:4];
            beat0_q   <= '0;
          end
        end
        REQ0: begin
          if (bus_ready) begin
            if (bus_we && split_q) begin
              state     <= REQ1;
              bus_addr  <= bus_addr + ADDR_W'(4);
              bus_wstrb <= strb1_q;
              bus_wdata <= wdata1_q;
            end else begin
              bus_req <= 1'b0;
              state   <= bus_we ? DONE : WAIT0;
            end
          end
        end
        WAIT0: begin
          if (bus_rvalid) begin
            beat0_q <= bus_rdata;
            if (split_q) begin
              state    <= REQ1;
              bus_req  <= 1'b1;
              bus_addr <= bus_addr + ADDR_W'(4);
            end else begin
              state      <= DONE;
              load_valid <= 1'b1;
              load_data  <= assemble(bus_rdata, 32'h0, off_q, size_q, uns_q);
            end
          end
        end
        REQ1: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            state   <= bus_we ? DONE : WAIT1;
          end
        end
        WAIT1: begin
          if (bus_rvalid) begin
            state      <= DONE;
            load_valid <= 1'b1;
            load_data  <= assemble(beat0_q, bus_rdata, off_q, size_q, uns_q);
          end
        end
        DONE: begin
          load_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: directed vector table, hand-written corner sequences and
// randomized traffic checked against a byte-addressed memory model.
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        store_mem, load_mem, load_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, load_valid;
  logic [31:0] load_data;
  logic        bus_req, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  data_mem_port #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .store_mem(store_mem), .load_mem(load_mem), .size(size),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata), .stall(stall),
    .load_valid(load_valid), .load_data(load_data), .bus_req(bus_req), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bus-side memory (written through strobes) and model memory (written per byte).
  bit [31:0] bmem [bit [31:0]];
  bit [31:0] mmem [bit [31:0]];

  function automatic bit [31:0] init_word(input bit [31:0] w);
    return w * 32'h9E3779B1 + 32'h01234567;
  endfunction
  function automatic bit [31:0] bget(input bit [31:0] w);
    return bmem.exists(w) ? bmem[w] : init_word(w);
  endfunction
  function automatic bit [31:0] mget(input bit [31:0] w);
    return mmem.exists(w) ? mmem[w] : init_word(w);
  endfunction
  function automatic bit [7:0] mbyte(input bit [31:0] a);
    bit [31:0] w;
    w = mget({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction
  function automatic int nbytes(input bit [1:0] sz);
    return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
  endfunction
  function automatic bit [31:0] mload(input bit [31:0] a, input bit [1:0] sz, input bit uns);
    bit [31:0] v;
    int n;
    n = nbytes(sz);
    v = '0;
    for (int unsigned i = 0; i < n; i++) v = v | (32'(mbyte(a + i)) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction
  task automatic mstore(input bit [31:0] a, input bit [1:0] sz, input bit [31:0] d);
    bit [31:0] ba, w;
    for (int unsigned i = 0; i < nbytes(sz); i++) begin
      ba = a + i;
      w = mget({ba[31:2], 2'b00});
      w[8*ba[1:0] +: 8] = d[8*i +: 8];
      mmem[{ba[31:2], 2'b00}] = w;
    end
  endtask
  task automatic preload(input bit [31:0] w, input bit [31:0] v);
    bmem[w] = v;
    mmem[w] = v;
  endtask

  // Bus responder state and knobs
  typedef struct { bit we; bit [31:0] a; bit [3:0] s; bit [31:0] d; } txn_t;
  txn_t txq[$];
  int   hs_cnt;
  int   ready_mode = 0;
  int   hold_cnt = 0;
  int   lat_min = 1, lat_max = 1;

  initial begin : responder
    bit pend, h_valid, h_we;
    int cnt;
    bit [31:0] p_addr, h_a, h_d, w;
    bit [3:0] h_s;
    txn_t t;
    pend = 0; h_valid = 0; cnt = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (h_valid && rst_n) begin
        chk("hold_req", bus_req, 1);
        chk("hold_we", bus_we, h_we);
        chk("hold_addr", bus_addr, h_a);
        chk("hold_wstrb", bus_wstrb, h_s);
        chk("hold_wdata", bus_wdata, h_d);
      end
      if (pend) chk("req_during_wait", bus_req, 0);
      bus_rvalid = 0;
      bus_rdata  = $urandom;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus_rvalid = 1;
          bus_rdata  = bget(p_addr);
          pend = 0;
        end
      end
      case (ready_mode)
        0: bus_ready = 1;
        1: bus_ready = ($urandom_range(0, 1) == 1);
        default: begin
          bus_ready = !(bus_req && hold_cnt > 0);
          if (bus_req && hold_cnt > 0) hold_cnt--;
        end
      endcase
      h_valid = bus_req && !bus_ready;
      h_we = bus_we; h_a = bus_addr; h_s = bus_wstrb; h_d = bus_wdata;
      if (bus_req && bus_ready) begin
        hs_cnt++;
        t.we = bus_we; t.a = bus_addr; t.s = bus_wstrb; t.d = bus_wdata;
        txq.push_back(t);
        chk("addr_align", {30'h0, bus_addr[1:0]}, 0);
        if (bus_we) begin
          w = bget(bus_addr);
          for (int unsigned i = 0; i < 4; i++) if (bus_wstrb[i]) w[8*i +: 8] = bus_wdata[8*i +: 8];
          bmem[bus_addr] = w;
        end else begin
          pend = 1;
          cnt = $urandom_range(lat_max, lat_min);
          p_addr = bus_addr;
        end
      end
    end
  end

  // Issue one request for one cycle, then wait (bounded) for stall to drop.
  task automatic do_op(input bit st, input bit ld, input bit [1:0] sz, input bit uns,
                       input bit [31:0] a, input bit [31:0] wd, output int lat);
    @(negedge clk);
    hs_cnt = 0;
    txq.delete();
    store_mem = st; load_mem = ld; size = sz; load_unsigned = uns; addr = a; wdata = wd;
    #1;
    chk("stall_accept", stall, 1);
    chk("valid_one_pulse", load_valid, 0);
    @(negedge clk);
    store_mem = 0; load_mem = 0; addr = $urandom; wdata = $urandom;
    size = 2'($urandom); load_unsigned = 1'($urandom);
    lat = 1;
    while (lat < 300) begin
      #1;
      if (!stall) break;
      @(negedge clk);
      lat++;
    end
    chk("done_within_bound", stall, 0);
  endtask

  typedef struct {
    bit st; bit [1:0] sz; bit uns; bit [31:0] a, wd, pre0, pre1, exp; int beats, lat;
  } vec_t;
  vec_t vt[10];

  initial begin : main
    int lat;
    bit [31:0] last_ld, w0, ra, rd, ex;
    bit rst_, rld, runs;
    bit [1:0] rsz;

    vt[0] = '{0, 2'd0, 0, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1, 3};
    vt[1] = '{0, 2'd1, 0, 32'h0000_0103, 32'h0, 32'h80123456, 32'h0, 32'hFFFFFF80, 1, 3};
    vt[2] = '{0, 2'd1, 1, 32'h0000_0103, 32'h0, 32'h80123456, 32'h0, 32'h00000080, 1, 3};
    vt[3] = '{1, 2'd0, 0, 32'h0000_0102, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h0, 2, 3};
    vt[4] = '{0, 2'd2, 0, 32'hFFFF_FFFF, 32'h0, 32'hAB000000, 32'h000000CD, 32'hFFFFCDAB, 2, 5};
    vt[5] = '{0, 2'd2, 1, 32'h0000_0101, 32'h0, 32'h12F0AB34, 32'h0, 32'h0000F0AB, 1, 3};
    vt[6] = '{0, 2'd3, 0, 32'h0000_0201, 32'h0, 32'h44332211, 32'h88776655, 32'h55443322, 2, 5};
    vt[7] = '{1, 2'd1, 0, 32'h0000_0303, 32'hAABBCCDD, 32'h01020304, 32'h0, 32'h0, 1, 2};
    vt[8] = '{0, 2'd2, 0, 32'h0000_0102, 32'h0, 32'h80017777, 32'h0, 32'hFFFF8001, 1, 3};
    vt[9] = '{1, 2'd0, 0, 32'h0000_0000, 32'h01020304, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 2};

    rst_n = 0; store_mem = 0; load_mem = 0; size = 0; load_unsigned = 0; addr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wstrb", bus_wstrb, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1;
    last_ld = '0;

    // Directed table at zero-wait bus
    ready_mode = 0; lat_min = 1; lat_max = 1;
    foreach (vt[i]) begin
      w0 = {vt[i].a[31:2], 2'b00};
      preload(w0, vt[i].pre0);
      preload(w0 + 32'd4, vt[i].pre1);
      do_op(vt[i].st, !vt[i].st, vt[i].sz, vt[i].uns, vt[i].a, vt[i].wd, lat);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_beats", i), hs_cnt, vt[i].beats);
      chk($sformatf("vec%0d_load_valid", i), load_valid, !vt[i].st);
      if (vt[i].st) begin
        mstore(vt[i].a, vt[i].sz, vt[i].wd);
        chk($sformatf("vec%0d_hold_data", i), load_data, last_ld);
        chk($sformatf("vec%0d_word0", i), bget(w0), mget(w0));
        chk($sformatf("vec%0d_word1", i), bget(w0 + 32'd4), mget(w0 + 32'd4));
      end else begin
        chk($sformatf("vec%0d_load_data", i), load_data, vt[i].exp);
        last_ld = vt[i].exp;
      end
    end

    // Misaligned SW lane placement, both beats
    do_op(1, 0, 2'd0, 0, 32'h0000_0102, 32'h11223344, lat);
    mstore(32'h0000_0102, 2'd0, 32'h11223344);
    chk("sw_beats", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("sw_b0_addr", txq[0].a, 32'h100);
      chk("sw_b0_strb", txq[0].s, 4'b1100);
      chk("sw_b0_data", txq[0].d, 32'h33440000);
      chk("sw_b1_addr", txq[1].a, 32'h104);
      chk("sw_b1_strb", txq[1].s, 4'b0011);
      chk("sw_b1_data", txq[1].d, 32'h00001122);
      chk("sw_b1_we", txq[1].we, 1);
    end

    // Backpressure: ready held low for 3 request cycles on SH
    ready_mode = 2; hold_cnt = 3;
    do_op(1, 0, 2'd2, 0, 32'h0000_0202, 32'h0000BEEF, lat);
    mstore(32'h0000_0202, 2'd2, 32'h0000BEEF);
    chk("bp_latency", lat, 5);
    chk("bp_beats", txq.size(), 1);
    if (txq.size() == 1) begin
      chk("bp_addr", txq[0].a, 32'h200);
      chk("bp_strb", txq[0].s, 4'b1100);
      chk("bp_data", txq[0].d, 32'hBEEF0000);
    end
    chk("bp_hold_data", load_data, last_ld);

    // Randomized traffic with random backpressure and read latency
    ready_mode = 1; lat_min = 1; lat_max = 3;
    for (int unsigned k = 0; k < 300; k++) begin
      rst_ = 1'($urandom);
      rld  = rst_ ? 1'($urandom) : 1'b1;
      rsz  = 2'($urandom);
      runs = 1'($urandom);
      ra   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                         : 32'h0000_1000 + $urandom_range(0, 31);
      rd   = $urandom;
      ex   = mload(ra, rsz, runs);
      do_op(rst_, rld, rsz, runs, ra, rd, lat);
      chk("rnd_beats", hs_cnt, ((ra[1:0] + nbytes(rsz)) > 4) ? 2 : 1);
      chk("rnd_load_valid", load_valid, !rst_);
      w0 = {ra[31:2], 2'b00};
      if (rst_) begin
        mstore(ra, rsz, rd);
        chk("rnd_hold_data", load_data, last_ld);
        chk("rnd_word0", bget(w0), mget(w0));
        chk("rnd_word1", bget(w0 + 32'd4), mget(w0 + 32'd4));
      end else begin
        chk("rnd_load_data", load_data, ex);
        last_ld = ex;
      end
    end

    // Reset while waiting for read data; the late rvalid must be ignored
    ready_mode = 0; lat_min = 5; lat_max = 5;
    @(negedge clk);
    load_mem = 1; size = 2'd0; addr = 32'h400; load_unsigned = 0;
    @(negedge clk);
    load_mem = 0;
    @(negedge clk);
    #1;
    chk("wait0_stall", stall, 1);
    rst_n = 0;
    #1;
    chk("rstw_bus_req", bus_req, 0);
    chk("rstw_stall", stall, 0);
    chk("rstw_load_valid", load_valid, 0);
    chk("rstw_load_data", load_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    lat_min = 1; lat_max = 1;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_valid", load_valid, 0);
      chk("post_rst_idle", stall | bus_req, 0);
    end
    ex = mload(32'h400, 2'd0, 0);
    do_op(0, 1, 2'd0, 0, 32'h400, 32'h0, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_valid", load_valid, 1);
    chk("post_rst_data", load_data, ex);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Memory-stage data port: the responder to the control unit's `store_mem` / `load_mem` / `size` requests. It turns one load or store per instruction into word-aligned transactions on the data-memory bus. Misaligned halfword and word accesses are split into two beats. The pipeline is stalled until the access completes, and load data is returned sign- or zero-extended for writeback.

## Interface
- `ADDR_W`, default 32: byte-address width. The bus is fixed at 32 data bits.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `store_mem` in 1: store request from the control unit.
- `load_mem` in 1: load request from the control unit.
- `size` in 2: access size. 2'd1 = byte, 2'd2 = halfword, 2'd0 = word; 2'd3 is treated as word.
- `load_unsigned` in 1: zero-extend load result (LBU/LHU).
- `addr` in ADDR_W: byte address from EX.
- `wdata` in 32: store data, right-aligned.
- `stall` out 1: hold the pipeline.
- `load_valid` out 1: one-cycle completion pulse for loads.
- `load_data` out 32: extended load result.
- `bus_req` out 1: request valid.
- `bus_ready` in 1: request accepted.
- `bus_we` out 1: write enable.
- `bus_addr` out ADDR_W: word address, `[1:0]` is always 0.
- `bus_wstrb` out 4: byte-lane write strobes.
- `bus_wdata` out 32: lane-positioned write data.
- `bus_rvalid` in 1: read data valid.
- `bus_rdata` in 32: read data.

## Operation
- **States:**
  - IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- **Accept:**
  - A request is accepted in IDLE when `store_mem|load_mem`. Size, addr, wdata and load_unsigned are latched, and the state moves to REQ0.
  - If both `store_mem` and `load_mem` are high, the access is a store.
- **Offset and split:**
  - `off = addr[1:0]`.
  - A split is required for halfword with off=3, and for word with off≠0.
- **Beat 0 lanes:**
  - `bus_addr = {addr[ADDR_W-1:2],2'b00}`.
  - Byte: `bus_wstrb = 4'b0001<<off`.
  - Halfword: `bus_wstrb = (4'b0011<<off)`, truncated to 4 bits.
  - Word: `bus_wstrb = (4'b1111<<off)`, truncated to 4 bits.
  - `bus_wdata = wdata<<8*off`.
- **Beat 1 lanes (split only):**
  - `bus_addr = beat0 addr + 4`, wrapping modulo 2^ADDR_W.
  - `bus_wstrb` carries the remaining low lanes.
  - `bus_wdata = wdata>>8*(4-off)`.
- **Request handshake:**
  - In REQ0/REQ1, `bus_req=1`. Address, we, strobes and data stay stable until a cycle with `bus_ready=1`.
  - Store: the handshake completes the beat, and the FSM goes to REQ1 (split) or DONE.
  - Load: the handshake moves the FSM to WAIT0/WAIT1. The FSM then waits for `bus_rvalid`, which may arrive in the following cycle or later.
- **Read data capture:**
  - `bus_rvalid` is ignored outside WAIT0/WAIT1.
  - In WAIT0, rdata is captured as beat0, then the FSM goes to REQ1 (split) or DONE.
  - In WAIT1, rdata is captured as beat1, then the FSM goes to DONE.
- **Load assembly:**
  - `r = ({beat1,beat0} >> 8*off)[31:0]`. beat1 is 0 when there is no split.
  - The low 8, 16 or 32 bits of r are taken, then zero-extended if `load_unsigned`, otherwise sign-extended.
- **DONE:**
  - `load_valid=1` for loads, 0 for stores. `load_data` holds the result.
  - `stall=0`.
  - The next state is always IDLE. Inputs are not re-sampled in DONE.
- **Stall:**
  - `stall = (IDLE & (store_mem|load_mem)) | (state ∉ {IDLE,DONE})`.
  - This is combinational in the accept cycle.
- **Output holding:** `load_data` keeps its last value until the next load completes.

## Timing
- **Reset values:** state IDLE. All outputs are 0: `bus_req`, `bus_we`, `bus_addr`, `bus_wstrb`, `bus_wdata`, `load_valid`, `load_data`. `stall` is 0 unless a request is present.
- **Reset mid-operation:** asserting `rst_n` low in any state drops `bus_req` immediately (asynchronously). Any pending beat is abandoned, and no `load_valid` is produced.
- **Aligned load, zero-wait bus:** accept at cycle T. `bus_req` is high in T+1, `bus_rvalid` arrives in T+2, `load_valid` is high in T+3. `stall` is high for T..T+2.
- **Aligned store, zero-wait bus:** accept at T, `bus_req` in T+1, DONE in T+2. `stall` is high for T..T+1.
- **Split access:** adds 1 cycle (store) or 2 cycles (load) per extra beat at zero wait.
- **Backpressure:** each cycle of `bus_ready=0` or late `bus_rvalid` extends `stall` by one cycle.
- **Single request on the bus:** only one bus request is outstanding at a time. `bus_req` is never asserted in WAIT states.

## Test plan
- **Aligned LW:** addr 0x100, ready=1, rdata 0xDEADBEEF one cycle after the handshake → bus_addr 0x100, wstrb 0, `load_valid` in T+3, `load_data` 0xDEADBEEF.
- **LB vs LBU:** addr 0x103, rdata 0x80123456 → signed gives 0xFFFFFF80; unsigned gives 0x00000080.
- **Misaligned SW:** addr 0x102, wdata 0x11223344 →
  - beat0: addr 0x100, wstrb 4'b1100, wdata 0x33440000.
  - beat1: addr 0x104, wstrb 4'b0011, wdata 0x00001122.
  - `stall` drops after beat1.
- **Misaligned signed LH with wrap:** addr 0xFFFFFFFF →
  - beat0 addr 0xFFFFFFFC, rdata 0xAB000000.
  - beat1 addr 0x00000000, rdata 0x000000CD.
  - Result `load_data` 0xFFFFCDAB.
- **Backpressure:** `bus_ready` low for 3 cycles on SH addr 0x202, wdata 0x0000BEEF →
  - bus_addr 0x200, wstrb 4'b1100, wdata 0xBEEF0000, all stable over 4 cycles.
  - `stall` stays high throughout; single beat.
- **Reset in WAIT0:** pull `rst_n` low while waiting for rvalid → `bus_req`/`stall`/`load_valid` go to 0 at once. A late `bus_rvalid` after reset is ignored, and the next LW completes normally.
